// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit, 32-cycle CALC; divider present only with MDU_DIV_EN
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] hi, lo, opb;
    logic        neg;
`ifdef MDU_DIV_EN
    logic        div_zero;
    logic [31:0] a_q;
`endif

    logic        a_sgn, b_sgn, sa, sb;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa    = a_sgn & A[31];
        sb    = b_sgn & B[31];
        mag_a = sa ? -A : A;
        mag_b = sb ? -B : B;
    end

    // hi/lo form the 64-bit product (multiply) or remainder/quotient pair (divide)
    logic [32:0] mul_sum;
    logic [31:0] step_hi, step_lo;
`ifdef MDU_DIV_EN
    logic [32:0] shifted;
    logic [33:0] diff;
`endif

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], lo[31:1]};
`ifdef MDU_DIV_EN
        shifted = {hi, lo[31]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        if (op_q[2]) begin
            if (!diff[33]) begin
                step_hi = diff[31:0];
                step_lo = {lo[30:0], 1'b1};
            end else begin
                step_hi = shifted[31:0];
                step_lo = {lo[30:0], 1'b0};
            end
        end
`endif
    end

    logic [63:0] prod;
    logic [31:0] final_res;

    always_comb begin
        prod      = neg ? -{step_hi, step_lo} : {step_hi, step_lo};
        final_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        if (op_q[2]) begin
`ifdef MDU_DIV_EN
            if (!op_q[1])
                final_res = div_zero ? 32'hFFFF_FFFF : (neg ? -step_lo : step_lo);
            else
                final_res = div_zero ? a_q : (neg ? -step_hi : step_hi);
`else
            final_res = 32'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            op_q  <= 3'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            opb   <= 32'd0;
            neg   <= 1'b0;
`ifdef MDU_DIV_EN
            div_zero <= 1'b0;
            a_q      <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        cnt   <= 6'd0;
                        op_q  <= op;
                        hi    <= 32'd0;
                        lo    <= op[2] ? mag_a : mag_b;
                        opb   <= op[2] ? mag_b : mag_a;
                        neg   <= (op[2] & op[1]) ? sa : (sa ^ sb);
`ifdef MDU_DIV_EN
                        div_zero <= (B == 32'd0);
                        a_q      <= A;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        res   <= final_res;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] res;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .A     (a_i),
        .B     (b_i),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_div(input logic [31:0] x);
`ifdef MDU_DIV_EN
        return x;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (op)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: begin
                ia = a;
                ib = b;
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else if (op[0]) begin
                    q = a / b;
                    r = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = a;
                    r = 32'd0;
                end else begin
                    q = ia / ib;
                    r = ia % ib;
                end
                return exp_div(op[1] ? r : q);
            end
        endcase
    endfunction

    // one operation with post-accept scrambling of the inputs; lat counts edges from accept to done inclusive
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output logic overlap);
        int t0;
        lat = -1;
        overlap = 1'b0;
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
        r = res;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    initial begin
        vec_t        dir[12];
        logic [31:0] r, r0, ea, eb;
        logic [2:0]  eo;
        logic        ov, seen_done, seen_busy;
        int          lat, t0, d1, d2, nd;

        dir[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir[1]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        dir[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        dir[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         exp_div(32'hFFFF_FFFD)};
        dir[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         exp_div(32'hFFFF_FFFF)};
        dir[6]  = '{3'b101, 32'd100,        32'd7,         exp_div(32'd14)};
        dir[7]  = '{3'b111, 32'd100,        32'd7,         exp_div(32'd2)};
        dir[8]  = '{3'b101, 32'd5,          32'd0,         exp_div(32'hFFFF_FFFF)};
        dir[9]  = '{3'b110, 32'd5,          32'd0,         exp_div(32'd5)};
        dir[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, exp_div(32'h8000_0000)};
        dir[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, exp_div(32'd0)};

        rst = 1'b1; start = 1'b0; op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_res",  64'(res),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (dir[i]) begin
            do_op(dir[i].op, dir[i].a, dir[i].b, r, lat, ov);
            check($sformatf("dir%0d_res", i), 64'(r), 64'(dir[i].exp));
            check($sformatf("dir%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("dir%0d_excl", i), 64'(ov), 64'd0);
        end
        r0 = res;
        repeat (3) @(posedge clk);
        #1;
        check("res_hold", 64'(res), 64'(r0));
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 30; i++) begin
            eo = 3'($urandom_range(0, 7));
            ea = $urandom;
            eb = $urandom;
            case ($urandom_range(0, 9))
                0: eb = 32'd0;
                1: begin ea = 32'h8000_0000; eb = 32'hFFFF_FFFF; end
                2: eb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(eo, ea, eb, r, lat, ov);
            check($sformatf("rnd%0d_op%0d_res", i, eo), 64'(r), 64'(model(eo, ea, eb)));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd33);
        end

        // start held high: second accept only in the DONE cycle
        eo = 3'b001; ea = $urandom; eb = $urandom;
        d1 = -1; d2 = -1; nd = 0;
        @(negedge clk);
        start = 1'b1; op_i = eo; a_i = ea; b_i = eb;
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 120 && nd < 2; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd == 0) begin
                    d1 = cyc;
                    check("b2b_res1", 64'(res), 64'(model(eo, ea, eb)));
                end else begin
                    d2 = cyc;
                end
                nd++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_first_lat", 64'(d1 - t0 + 1), 64'd33);
        check("b2b_gap", 64'(d2 - d1 + 1), 64'd34);
        check("b2b_res2", 64'(res), 64'(model(eo, ea, eb)));
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", 64'(busy), 64'd0);

        // reset in CALC cycle 10 aborts with no done; start during reset is ignored
        @(negedge clk);
        start = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res",  64'(res),  64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        seen_done = 1'b0; seen_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_start", 64'(seen_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL be an iterative RV32M multiply/divide unit that sits beside the ALU, takes the same decoded operands, and feeds the writeback mux.
REQ-002 Parameter: WIDTH, 32, operand/result width; only 32 SHALL be supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only when the unit can accept (see REQ-012).
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 A  input  32  rs1 operand (multiplicand/dividend).
REQ-008 B  input  32  rs2 operand (multiplier/divisor).
REQ-009 busy  output  1  high while state is CALC.
REQ-010 done  output  1  one-cycle pulse; res valid in that cycle.
REQ-011 res  output  32  result; held stable from done until the next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; start SHALL be accepted in IDLE or DONE (back-to-back) and ignored in CALC.
REQ-013 On accept, op/A/B SHALL be latched; later changes on op/A/B SHALL not affect the operation.
REQ-014 CALC SHALL last exactly 32 cycles (6-bit counter, 0..31) for every op, including special cases; then DONE for exactly 1 cycle, then IDLE unless start was accepted in DONE.
REQ-015 Latency: start sampled at edge E0 -> busy=1 after E0 through E32 -> done=1 in the cycle after E32 (33 edges start-to-done).
REQ-016 Multiply SHALL be radix-2 shift-add on magnitudes with a 64-bit product, sign-corrected at the end: MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned.
REQ-017 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-018 Divide SHALL be restoring, one quotient bit per CALC cycle, on magnitudes; quotient sign = sign(A) xor sign(B); remainder sign = sign(A) (DIV/REM only).
REQ-019 Divide-by-zero: DIV/DIVU quotient = 32'hFFFFFFFF; REM/REMU = A.
REQ-020 Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): DIV = 32'h80000000; REM = 0.
REQ-021 done SHALL never be high while busy is high.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, counter 0, busy=0, done=0, res=0, regardless of state.
REQ-023 Reset during CALC SHALL abort the operation with no done pulse; start asserted together with rst SHALL be ignored.

Configuration
REQ-024 Macro MDU_DIV_EN: defined -> divider datapath present, REQ-018..REQ-020 apply.
REQ-025 Without MDU_DIV_EN: divider logic SHALL be absent; ops 100-111 SHALL follow the identical handshake/latency and return res=0.

Verification
REQ-026 MUL A=7, B=-3 (32'hFFFFFFFD) -> done 33 edges after start, res=32'hFFFFFFEB; MULH same operands -> 32'hFFFFFFFF.
REQ-027 MULHU A=B=32'hFFFFFFFF -> res=32'hFFFFFFFE; MULHSU A=-1, B=2 -> 32'hFFFFFFFF.
REQ-028 DIV A=-7, B=2 -> 32'hFFFFFFFD; REM same -> 32'hFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
REQ-029 DIVU A=5, B=0 -> 32'hFFFFFFFF; REM A=5, B=0 -> 5; DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000, REM -> 0.
REQ-030 start held high through CALC -> single operation, second accept only in DONE cycle, next done exactly 34 edges after the first done.
REQ-031 rst pulsed at CALC cycle 10 -> busy=0, res=0 next cycle, no done pulse; build without MDU_DIV_EN, DIVU 100/7 -> res=0 at standard latency.
